// File: rtl/tau_pkg.sv
// Shared definitions for the unary-by-binary dot-product MAC:
// controller states and default operand geometry.
package tau_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tau_state_t;

    localparam int TAU_BITWIDTH = 32'd8;
    localparam int TAU_LANES    = 32'd4;

endpackage

// File: rtl/tau_lane.sv
// One multiply lane: holds the unary mask and binary operand, and each step
// retires the highest set mask bit k, contributing b << k.
module tau_lane #(
    parameter int BITWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [BITWIDTH-1:0]   load_mask,
    input  logic [BITWIDTH-1:0]   load_b,
    output logic [2*BITWIDTH-1:0] contrib,
    output logic                  empty,
    output logic                  last
);

    localparam int KW = $clog2(BITWIDTH);

    logic [BITWIDTH-1:0] mask_r;
    logic [BITWIDTH-1:0] b_r;
    logic [BITWIDTH-1:0] bit_s;
    logic [KW-1:0]       k_s;

    // Priority encode: the highest set bit wins because later indices overwrite.
    always_comb begin
        k_s = '0;
        for (int i = 0; i < BITWIDTH; i++) begin
            k_s = mask_r[i] ? i[KW-1:0] : k_s;
        end
    end

    // One-hot of the bit retired this step, and the lane's shifted product term.
    always_comb begin
        bit_s   = {{(BITWIDTH-1){1'b0}}, 1'b1} << k_s;
        empty   = (mask_r == '0);
        contrib = empty ? '0 : ({{BITWIDTH{1'b0}}, b_r} << k_s);
        last    = ((mask_r & ~bit_s) == '0);
    end

    // Operand registers: load on accept, peel one mask bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r <= '0;
            b_r    <= '0;
        end else if (load) begin
            mask_r <= load_mask;
            b_r    <= load_b;
        end else if (step) begin
            mask_r <= mask_r & ~bit_s;
            b_r    <= b_r;
        end else begin
            mask_r <= mask_r;
            b_r    <= b_r;
        end
    end

endmodule

// File: rtl/tau_dot_mac.sv
// Dot-product MAC with unary-coded a operands: RUN lasts as many cycles as the
// densest lane mask, summing all lane terms into the accumulator every cycle.
module tau_dot_mac
    import tau_pkg::*;
#(
    parameter int BITWIDTH  = TAU_BITWIDTH,
    parameter int LANES     = TAU_LANES,
    parameter int ACC_WIDTH = 2*BITWIDTH + $clog2(LANES) + 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*BITWIDTH-1:0]     in_a,
    input  logic [LANES*BITWIDTH-1:0]     in_b,
    input  logic                          in_acc_clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          out_acc,
    output logic [$clog2(BITWIDTH+1)-1:0] out_cycles,
    output logic                          busy
);

    localparam int CW = $clog2(BITWIDTH+1);
    localparam logic [CW-1:0] CYC_ONE = {{(CW-1){1'b0}}, 1'b1};

    tau_state_t state_r;
    tau_state_t next_s;

    logic [ACC_WIDTH-1:0]  acc_r;
    logic [ACC_WIDTH-1:0]  out_acc_r;
    logic [CW-1:0]         out_cycles_r;
    logic [CW-1:0]         cnt_r;
    logic                  ready_r;
    logic                  valid_r;
    logic                  busy_r;

    logic                  accept_s;
    logic                  step_s;
    logic                  run_end_s;
    logic [ACC_WIDTH-1:0]  acc_base_s;
    logic [ACC_WIDTH-1:0]  sum_s;
    logic [2*BITWIDTH-1:0] contrib_s [LANES];
    logic [LANES-1:0]      empty_s;
    logic [LANES-1:0]      last_s;

    assign accept_s  = in_valid & ready_r;
    assign step_s    = (state_r == ST_RUN);
    assign run_end_s = &(last_s | empty_s);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        tau_lane #(
            .BITWIDTH (BITWIDTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load      (accept_s),
            .step      (step_s),
            .load_mask (in_a[l*BITWIDTH +: BITWIDTH]),
            .load_b    (in_b[l*BITWIDTH +: BITWIDTH]),
            .contrib   (contrib_s[l]),
            .empty     (empty_s[l]),
            .last      (last_s[l])
        );
    end

    // Single adder tree over all lane terms, plus the accumulator start value.
    always_comb begin
        sum_s = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_s = sum_s + ACC_WIDTH'(contrib_s[l]);
        end
        acc_base_s = in_acc_clear ? '0 : acc_r;
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode; an all-zero operand set skips RUN entirely.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_s = (|in_a) ? ST_RUN : ST_DONE;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (run_end_s) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_DONE;
                end
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // Datapath and registered handshake flags; results latch only on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r        <= '0;
            out_acc_r    <= '0;
            out_cycles_r <= '0;
            cnt_r        <= '0;
            ready_r      <= 1'b1;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            ready_r <= (next_s == ST_IDLE);
            valid_r <= (next_s == ST_DONE);
            busy_r  <= (next_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_r <= acc_base_s;
                        cnt_r <= '0;
                        if (~|in_a) begin
                            out_acc_r    <= acc_base_s;
                            out_cycles_r <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_r + sum_s;
                    cnt_r <= cnt_r + CYC_ONE;
                    if (run_end_s) begin
                        out_acc_r    <= acc_r + sum_s;
                        out_cycles_r <= cnt_r + CYC_ONE;
                    end
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready   = ready_r;
    assign out_valid  = valid_r;
    assign busy       = busy_r;
    assign out_acc    = out_acc_r;
    assign out_cycles = out_cycles_r;

endmodule

// File: tb/tb_tau_dot_mac.sv
// Directed bench for tau_dot_mac: expected results are queued when an
// operation is issued and compared when the DUT presents its result.
module tb_tau_dot_mac;

    localparam int BW = 8;
    localparam int LN = 4;
    localparam int AW = 2*BW + $clog2(LN) + 8;
    localparam int CW = $clog2(BW+1);

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [LN*BW-1:0]  in_a;
    logic [LN*BW-1:0]  in_b;
    logic              in_acc_clear;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_acc;
    logic [CW-1:0]     out_cycles;
    logic              busy;

    typedef struct {
        logic [AW-1:0] acc;
        logic [CW-1:0] cycles;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] model_acc;
    int            checks = 0;
    int            errors = 0;

    tau_dot_mac #(.BITWIDTH(BW), .LANES(LN)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_acc_clear (in_acc_clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_acc      (out_acc),
        .out_cycles   (out_cycles),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent model: wrap-around sum of products, P = densest mask.
    task automatic push_op(input logic [LN*BW-1:0] a, input logic [LN*BW-1:0] b, input logic clr);
        exp_t          e;
        int            p;
        logic [AW-1:0] s;
        logic [BW-1:0] av;
        logic [BW-1:0] bv;
        p = 0;
        s = clr ? '0 : model_acc;
        for (int l = 0; l < LN; l++) begin
            av = a[l*BW +: BW];
            bv = b[l*BW +: BW];
            s  = s + AW'(av) * AW'(bv);
            if ($countones(av) > p) p = $countones(av);
        end
        model_acc = s;
        e.acc     = s;
        e.cycles  = CW'(p);
        e.lat     = p + 1;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [LN*BW-1:0] a, input logic [LN*BW-1:0] b, input logic clr);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check("ready_wait", in_ready, 1);
        in_a         = a;
        in_b         = b;
        in_acc_clear = clr;
        in_valid     = 1'b1;
        push_op(a, b, clr);
    endtask

    // Accept edge, then wait for the result; optionally stall the consumer.
    task automatic collect(input int hold);
        exp_t e;
        int   lat;
        tick();
        lat      = 1;
        in_valid = 1'b0;
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.lat > 1) begin
                check("busy_run", busy, 1);
                check("ready_run", in_ready, 0);
            end
            while (!out_valid && lat < 40) begin
                tick();
                lat++;
            end
            check("latency", lat, e.lat);
            check("out_valid", out_valid, 1);
            check("out_acc", out_acc, e.acc);
            check("out_cycles", out_cycles, e.cycles);
            for (int h = 0; h < hold; h++) begin
                in_valid     = ~in_valid;
                in_a         = $urandom;
                in_b         = $urandom;
                in_acc_clear = 1'($urandom_range(0, 1));
                tick();
                check("hold_acc", out_acc, e.acc);
                check("hold_cycles", out_cycles, e.cycles);
                check("hold_ready", in_ready, 0);
                check("hold_valid", out_valid, 1);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("release_ready", in_ready, 1);
            check("release_valid", out_valid, 0);
            check("release_busy", busy, 0);
        end
    endtask

    initial begin
        logic [LN*BW-1:0] a;
        logic [LN*BW-1:0] b;
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_acc_clear = 1'b0;
        out_ready    = 1'b0;
        model_acc    = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_acc", out_acc, 0);
        check("rst_cycles", out_cycles, 0);

        // a0=5 (two bits) times 3
        issue(32'h0000_0005, 32'h0303_0303, 1'b1);
        collect(0);

        // all lanes 255*255, eight RUN cycles
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        collect(0);

        // accumulate across two operations
        issue(32'h0000_0002, 32'h0000_000A, 1'b1);
        collect(0);
        issue(32'h0000_0003, 32'h0000_0007, 1'b0);
        collect(0);

        // zero masks: result the cycle after accept
        issue(32'h0000_0000, 32'h1234_5678, 1'b1);
        collect(0);

        // mixed lane densities, accumulate, then stalled consumer
        issue(32'h8001_7F10, 32'h0102_C3FF, 1'b1);
        collect(0);
        issue(32'h0F0F_A5C3, 32'h9988_7766, 1'b0);
        collect(5);

        // zero operand set without clear keeps the held total
        issue(32'h0000_0000, 32'h0000_0000, 1'b0);
        collect(0);

        // drive the accumulator past 2^AW to exercise wrap
        for (int n = 0; n < 260; n++) begin
            issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
            collect(0);
        end

        // a few random operations
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            b = $urandom;
            issue(a, b, 1'($urandom_range(0, 1)));
            collect(n % 3);
        end

        // reset mid-RUN abandons the operation
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midrun_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        model_acc = '0;
        check("abort_ready", in_ready, 1);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_acc", out_acc, 0);
        check("abort_cycles", out_cycles, 0);
        tick();
        check("abort_quiet", out_valid, 0);
        issue(32'h0000_0001, 32'h0000_0009, 1'b0);
        collect(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
